// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer that shares one 4-bit combinational ALU
// among NUM_REQ requesters. One operation is in flight at a time:
// IDLE grants a request, EXEC captures the ALU result, and RESP holds the
// response until the consumer takes it.
module alu_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [4*NUM_REQ-1:0] req_a,
   input  logic [4*NUM_REQ-1:0] req_b,
   input  logic [3*NUM_REQ-1:0] req_op,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [3:0]           alu_a,
   output logic [3:0]           alu_b,
   output logic [2:0]           alu_op,
   input  logic [3:0]           alu_result,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [3:0]           rsp_result,
   output logic [7:0]           op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] grant_idx;
   logic            grant_found;

   // Unpacked views of the per-requester payloads.
   logic [3:0]      a_arr    [NUM_REQ];
   logic [3:0]      b_arr    [NUM_REQ];
   logic [2:0]      op_arr   [NUM_REQ];
   // cand_idx[k] is the requester examined k-th, starting at the pointer.
   logic [ID_W-1:0] cand_idx [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi]    = req_a[4*gi +: 4];
         assign b_arr[gi]    = req_b[4*gi +: 4];
         assign op_arr[gi]   = req_op[3*gi +: 3];
         assign cand_idx[gi] = ID_W'((int'(rr_ptr) + gi) % NUM_REQ);
      end
   endgenerate

   // Pick the first valid requester at or after rr_ptr, searching upward with wrap.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && req_valid[cand_idx[k]]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx[k];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the one-hot accept strobe (only ever in IDLE).
   always_comb begin
      state_next = state;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               // Gated by rst_n so no accept is signalled while reset is held.
               req_ready[grant_idx] = rst_n;
               state_next           = EXEC;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand latch on grant, result capture in EXEC, response retire in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_valid  <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  alu_a  <= a_arr[grant_idx];
                  alu_b  <= b_arr[grant_idx];
                  alu_op <= op_arr[grant_idx];
                  rsp_id <= grant_idx;
                  rr_ptr <= ID_W'((int'(grant_idx) + 1) % NUM_REQ);
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_valid  <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 8'd1;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A behavioural ALU closes the loop;
// expected results are hand-computed constants.
module tb_alu_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [4*N-1:0] req_a = '0;
   logic [4*N-1:0] req_b = '0;
   logic [3*N-1:0] req_op = '0;
   logic [N-1:0]   req_ready;
   logic [3:0]     alu_a;
   logic [3:0]     alu_b;
   logic [2:0]     alu_op;
   logic [3:0]     alu_result;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [IW-1:0]  rsp_id;
   logic [3:0]     rsp_result;
   logic [7:0]     op_count;

   int n_checks = 0;
   int n_errors = 0;

   alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .req_ready  (req_ready),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   // Shared combinational ALU.
   always_comb begin
      case (alu_op)
         3'd0:    alu_result = alu_a + alu_b;
         3'd1:    alu_result = alu_a - alu_b;
         3'd2:    alu_result = alu_a & alu_b;
         3'd3:    alu_result = alu_a | alu_b;
         3'd4:    alu_result = alu_a ^ alu_b;
         3'd5:    alu_result = {alu_a[2:0], 1'b0};
         3'd6:    alu_result = {1'b0, alu_a[3:1]};
         default: alu_result = 4'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      req_a[4*id +: 4]  = a;
      req_b[4*id +: 4]  = b;
      req_op[3*id +: 3] = op;
   endtask

   // Poll (bounded) until a response is presented; return its id and result.
   task automatic wait_rsp(output logic [IW-1:0] id, output logic [3:0] res);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (rsp_valid !== 1'b1) check("rsp_timeout", 32'(rsp_valid), 32'd1);
      id  = rsp_id;
      res = rsp_result;
   endtask

   // One isolated request with rsp_ready=1; checks accept, latency and response.
   task automatic single_op(input int id, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op, input logic [3:0] exp_res);
      set_req(id, a, b, op);
      req_valid = N'(1) << id;
      #1;
      check($sformatf("ready_r%0d_op%0d", id, op), 32'(req_ready), 32'(N'(1) << id));
      tick();                       // accepted
      req_valid = '0;
      check("exec_no_rsp", 32'(rsp_valid), 32'd0);
      tick();                       // response presented
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_id", 32'(rsp_id), 32'(id));
      check($sformatf("result_op%0d", op), 32'(rsp_result), 32'(exp_res));
      tick();                       // handshake
      check("rsp_cleared", 32'(rsp_valid), 32'd0);
   endtask

   logic [3:0]    sweep_exp [8];
   logic [IW-1:0] got_id;
   logic [3:0]    got_res;
   int            order02 [3];

   initial begin
      sweep_exp = '{4'hD, 4'h7, 4'h2, 4'hB, 4'h9, 4'h4, 4'h5, 4'h0};
      order02   = '{2, 0, 2};

      // Reset state, with requests pending to confirm no accept during reset.
      req_valid = '1;
      #2;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      req_valid = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Requester 1: 9+8 wraps to 1.
      single_op(1, 4'd9, 4'd8, 3'd0, 4'd1);
      check("op_count_1", 32'(op_count), 32'd1);

      // Opcode sweep from requester 0 with A=0xA, B=0x3.
      for (int op = 0; op < 8; op++) begin
         single_op(0, 4'hA, 4'h3, 3'(op), sweep_exp[op]);
      end
      check("op_count_9", 32'(op_count), 32'd9);

      // Pointer is now 1; only requesters 0 and 2 valid -> grants 2,0,2.
      set_req(0, 4'd1, 4'd1, 3'd0);
      set_req(2, 4'd2, 4'd2, 3'd0);
      req_valid = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         wait_rsp(got_id, got_res);
         check($sformatf("skip_id_%0d", k), 32'(got_id), 32'(order02[k]));
         check($sformatf("skip_res_%0d", k), 32'(got_res), (order02[k] == 2) ? 32'd4 : 32'd2);
         tick();
      end
      req_valid = '0;
      check("op_count_12", 32'(op_count), 32'd12);

      // Stall in RESP for 5 cycles while requester 0 waits.
      rsp_ready = 1'b0;
      set_req(3, 4'd5, 4'd6, 3'd4);
      req_valid = 4'b1000;
      #1;
      check("stall_ready_r3", 32'(req_ready), 32'b1000);
      tick();
      req_valid = 4'b0001;
      tick();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("stall_valid_%0d", k), 32'(rsp_valid), 32'd1);
         check($sformatf("stall_id_%0d", k), 32'(rsp_id), 32'd3);
         check($sformatf("stall_res_%0d", k), 32'(rsp_result), 32'd3);
         check($sformatf("stall_ready_%0d", k), 32'(req_ready), 32'd0);
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      check("stall_done_valid", 32'(rsp_valid), 32'd0);
      check("op_count_13", 32'(op_count), 32'd13);

      // Fresh reset, then all requesters continuously valid for 8 grants.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < N; i++) set_req(i, 4'(i), 4'd1, 3'd0);
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         wait_rsp(got_id, got_res);
         check($sformatf("rr_id_%0d", k), 32'(got_id), 32'(k % 4));
         check($sformatf("rr_res_%0d", k), 32'(got_res), 32'(k % 4 + 1));
         tick();
      end
      req_valid = '0;
      check("op_count_8", 32'(op_count), 32'd8);

      // Reset while in EXEC: transaction dropped, everything back to reset values.
      set_req(1, 4'd7, 4'd7, 3'd0);
      req_valid = 4'b0010;
      tick();
      check("exec_alu_a", 32'(alu_a), 32'd7);
      check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_alu_a", 32'(alu_a), 32'd0);
      check("mid_rst_alu_b", 32'(alu_b), 32'd0);
      check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_op_count", 32'(op_count), 32'd0);
      check("mid_rst_req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("post_rst_no_rsp_%0d", k), 32'(rsp_valid), 32'd0);
      end
      check("post_rst_op_count", 32'(op_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
